// File: rtl/stream_mux_pkg.sv
// Shared types and the wrap-around first-set search used by the stream_mux round-robin arbiter.
package stream_mux_pkg;

    typedef enum logic {MODE_SEL = 1'b0, MODE_RR = 1'b1} mux_mode_e;

    localparam int MAX_N     = 16;
    localparam int MAX_SEL_W = 4;

    // Returns the first requesting index at or after ptr (wrapping modulo n), or -1 if none.
    function automatic int rr_first_idx(
        input logic [MAX_N-1:0] req,
        input int               ptr,
        input int               n
    );
        int first;
        int idx;
        first = -1;
        // Descending scan: the candidate nearest to ptr is written last and wins.
        for (int off = MAX_N - 1; off >= 0; off--) begin
            if (off < n) begin
                idx = ptr + off;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[MAX_SEL_W-1:0]]) begin
                    first = idx;
                end
            end
        end
        return first;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: wrap-around first-set grant starting at an internal pointer,
// which moves past the granted channel when the caller reports a completed transfer.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  req,
    input  logic             enable,
    input  logic             advance,
    output logic [N_IN-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_next;
    logic [MAX_N-1:0] w_req_ext;
    int               w_first;

    always_comb begin
        w_req_ext            = '0;
        w_req_ext[N_IN-1:0]  = req;
        w_first              = rr_first_idx(w_req_ext, int'(r_ptr), N_IN);
        grant                = '0;
        grant_idx            = '0;
        if (enable && (w_first >= 0)) begin
            grant[w_first[SEL_W-1:0]] = 1'b1;
            grant_idx                 = w_first[SEL_W-1:0];
        end
    end

    always_comb begin
        w_ptr_next = r_ptr;
        if (advance) begin
            w_ptr_next = (int'(grant_idx) == N_IN - 1) ? '0 : grant_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-input registered stream multiplexer with valid/ready on every port; the grant comes
// from an explicit select or from round-robin arbitration, and feeds one output register.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      select,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_src,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic             w_mode_rr;
    logic             w_load;
    logic             w_xfer;
    logic [N_IN-1:0]  w_rr_grant;
    logic [N_IN-1:0]  w_sel_grant;
    logic [N_IN-1:0]  w_grant;
    logic [SEL_W-1:0] w_rr_idx;
    logic [SEL_W-1:0] w_grant_idx;
    logic [WIDTH-1:0] w_grant_data;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_src;

    assign w_mode_rr = (mux_mode_e'(mode) == MODE_RR);

    rr_arbiter #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .enable    (w_mode_rr),
        .advance   (w_xfer && w_mode_rr),
        .grant     (w_rr_grant),
        .grant_idx (w_rr_idx)
    );

    // An out-of-range select matches no channel, so it yields no grant.
    always_comb begin
        w_sel_grant = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (select == SEL_W'(i)) begin
                w_sel_grant[i] = in_valid[i];
            end
        end
    end

    assign w_grant     = w_mode_rr ? w_rr_grant : w_sel_grant;
    assign w_grant_idx = w_mode_rr ? w_rr_idx : select;

    // No acknowledge while reset holds the output register, else that beat would be lost.
    assign w_load   = rst_n && (!r_out_valid || out_ready);
    assign w_xfer   = w_load && (|w_grant);
    assign in_ready = w_grant & {N_IN{w_load}};

    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (w_grant[i]) begin
                w_grant_data |= in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_load) begin
            if (|w_grant) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_grant_data;
                r_out_src   <= w_grant_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_stream_mux;

    localparam int WIDTH = 8;
    localparam int N_IN  = 4;
    localparam int SEL_W = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  mode;
    logic [SEL_W-1:0]      select;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [N_IN-1:0]       in_valid;
    logic [N_IN-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_src;
    logic                  out_valid;
    logic                  out_ready;

    logic                  mode8 = 1'b0;
    logic [2:0]            select8 = '0;
    logic [8*WIDTH-1:0]    in_data8 = '0;
    logic [7:0]            in_valid8 = '0;
    logic [7:0]            in_ready8;
    logic [WIDTH-1:0]      out_data8;
    logic [2:0]            out_src8;
    logic                  out_valid8;
    logic                  out_ready8 = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_src;
    int               m_ptr;
    int               exp_g;
    logic [N_IN-1:0]  exp_ready;

    always #5 clk = ~clk;

    stream_mux #(.WIDTH(WIDTH), .N_IN(N_IN)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .select(select), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_src(out_src),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux #(.WIDTH(WIDTH), .N_IN(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .mode(mode8), .select(select8), .in_data(in_data8),
        .in_valid(in_valid8), .in_ready(in_ready8), .out_data(out_data8), .out_src(out_src8),
        .out_valid(out_valid8), .out_ready(out_ready8)
    );

    function automatic int model_grant();
        if (mode == 1'b0) begin
            return in_valid[select] ? int'(select) : -1;
        end
        for (int k = 0; k < N_IN; k++) begin
            if (in_valid[(m_ptr + k) % N_IN]) return (m_ptr + k) % N_IN;
        end
        return -1;
    endfunction

    task automatic apply(input bit md, input int sel, input logic [N_IN-1:0] v,
                         input logic [N_IN*WIDTH-1:0] d, input bit ordy);
        mode = md; select = SEL_W'(sel); in_valid = v; in_data = d; out_ready = ordy;
        #1;
        exp_g     = model_grant();
        exp_ready = '0;
        if (rst_n && exp_g >= 0 && (!m_valid || out_ready)) exp_ready[exp_g] = 1'b1;
    endtask

    task automatic tick();
        if (rst_n && (!m_valid || out_ready)) begin
            if (exp_g >= 0) begin
                m_data  = in_data[exp_g*WIDTH +: WIDTH];
                m_src   = exp_g;
                m_valid = 1'b1;
                if (mode) m_ptr = (exp_g + 1) % N_IN;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        apply(1'b1, 0, 4'hF, 32'h44332211, 1'b1);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests_run++; if (out_data !== 8'h00) begin tests_failed++;
            $display("FAIL reset_out_data: got %h want 00", out_data); end
        tests_run++; if (out_src !== 2'd0) begin tests_failed++;
            $display("FAIL reset_out_src: got %0d want 0", out_src); end
        tests_run++; if (in_ready !== 4'b0000) begin tests_failed++;
            $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
        tick();
        rst_n = 1'b1;
        apply(1'b1, 0, 4'hF, 32'h44332211, 1'b1);
        tests_run++; if (in_ready !== 4'b0001) begin tests_failed++;
            $display("FAIL reset_first_grant: got %b want 0001", in_ready); end
        tick();
        tests_run++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 8'h11) begin
            tests_failed++;
            $display("FAIL reset_first_beat: got v=%b src=%0d d=%h want v=1 src=0 d=11",
                     out_valid, out_src, out_data); end
    endtask

    task automatic test_sel_basic();
        do_reset();
        apply(1'b0, 2, 4'b0100, 32'h11A52233, 1'b1);
        tests_run++; if (in_ready !== 4'b0100) begin tests_failed++;
            $display("FAIL sel_in_ready: got %b want 0100", in_ready); end
        tick();
        tests_run++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd2) begin
            tests_failed++;
            $display("FAIL sel_beat: got v=%b d=%h src=%0d want v=1 d=a5 src=2",
                     out_valid, out_data, out_src); end
        // 8-input instance: load from ch5, then ch5 goes idle while others request
        mode8 = 1'b0; select8 = 3'd5; in_valid8 = 8'b0010_0000;
        in_data8 = '0; in_data8[5*WIDTH +: WIDTH] = 8'h5A; out_ready8 = 1'b1;
        #1;
        tests_run++; if (in_ready8 !== 8'b0010_0000) begin tests_failed++;
            $display("FAIL sel8_in_ready: got %b want 00100000", in_ready8); end
        @(posedge clk); #1;
        tests_run++; if (out_valid8 !== 1'b1 || out_src8 !== 3'd5 || out_data8 !== 8'h5A) begin
            tests_failed++;
            $display("FAIL sel8_beat: got v=%b src=%0d d=%h want v=1 src=5 d=5a",
                     out_valid8, out_src8, out_data8); end
        in_valid8 = 8'b1101_1111;
        #1;
        tests_run++; if (in_ready8 !== 8'h00) begin tests_failed++;
            $display("FAIL sel8_idle_ready: got %b want 00000000", in_ready8); end
        @(posedge clk); #1;
        tests_run++; if (out_valid8 !== 1'b0 || out_src8 !== 3'd5 || out_data8 !== 8'h5A) begin
            tests_failed++;
            $display("FAIL sel8_idle_drain: got v=%b src=%0d d=%h want v=0 src=5 d=5a",
                     out_valid8, out_src8, out_data8); end
        in_valid8 = '0;
    endtask

    task automatic test_rr_fairness();
        int seq1 [6] = '{0, 1, 2, 3, 0, 1};
        int seq2 [4] = '{1, 3, 1, 3};
        logic [N_IN*WIDTH-1:0] d;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            d = $urandom;
            apply(1'b1, 0, 4'hF, d, 1'b1);
            tests_run++; if (in_ready !== exp_ready || !in_ready[seq1[k]]) begin tests_failed++;
                $display("FAIL rr_all_ready[%0d]: got %b want %b", k, in_ready, exp_ready); end
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || int'(out_src) != seq1[k] ||
                out_data !== d[seq1[k]*WIDTH +: WIDTH]) begin
                tests_failed++;
                $display("FAIL rr_all_seq[%0d]: got v=%b src=%0d d=%h want v=1 src=%0d d=%h",
                         k, out_valid, out_src, out_data, seq1[k], d[seq1[k]*WIDTH +: WIDTH]);
            end
        end
        do_reset();
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, 0, 4'b1010, $urandom, 1'b1);
            tick();
            tests_run++; if (out_valid !== 1'b1 || int'(out_src) != seq2[k]) begin
                tests_failed++;
                $display("FAIL rr_1010_seq[%0d]: got v=%b src=%0d want v=1 src=%0d",
                         k, out_valid, out_src, seq2[k]); end
        end
    endtask

    task automatic test_backpressure();
        logic [N_IN*WIDTH-1:0] d;
        do_reset();
        apply(1'b0, 1, 4'b0010, 32'h00003C00, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 0, 4'hF, $urandom, 1'b0);
            tests_run++; if (in_ready !== 4'b0000) begin tests_failed++;
                $display("FAIL bp_in_ready[%0d]: got %b want 0000", k, in_ready); end
            tick();
            tests_run++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_src !== 2'd1) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h src=%0d want v=1 d=3c src=1",
                         k, out_valid, out_data, out_src); end
        end
        d = $urandom;
        apply(1'b1, 0, 4'hF, d, 1'b1);
        tests_run++; if (in_ready !== 4'b0001) begin tests_failed++;
            $display("FAIL bp_release_ready: got %b want 0001", in_ready); end
        tick();
        tests_run++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== d[7:0]) begin
            tests_failed++;
            $display("FAIL bp_release_beat: got v=%b src=%0d d=%h want v=1 src=0 d=%h",
                     out_valid, out_src, out_data, d[7:0]); end
    endtask

    task automatic test_mode_switch();
        do_reset();
        apply(1'b1, 0, 4'b0100, $urandom, 1'b1);
        tick();
        apply(1'b1, 0, 4'b0001, $urandom, 1'b1);
        tests_run++; if (in_ready !== 4'b0001) begin tests_failed++;
            $display("FAIL ms_wrap_ready: got %b want 0001", in_ready); end
        tick();
        apply(1'b0, 3, 4'b1000, 32'hC7000000, 1'b1);
        tests_run++; if (in_ready !== 4'b1000) begin tests_failed++;
            $display("FAIL ms_sel_ready: got %b want 1000", in_ready); end
        tick();
        tests_run++; if (out_src !== 2'd3 || out_data !== 8'hC7) begin tests_failed++;
            $display("FAIL ms_sel_beat: got src=%0d d=%h want src=3 d=c7", out_src, out_data); end
        apply(1'b1, 0, 4'hF, $urandom, 1'b1);
        tests_run++; if (in_ready !== 4'b0010) begin tests_failed++;
            $display("FAIL ms_ptr_held: got %b want 0010", in_ready); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        apply(1'b0, 2, 4'b0100, 32'h00990000, 1'b0);
        tick();
        apply(1'b0, 2, 4'b0100, 32'h00990000, 1'b0);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++;
            $display("FAIL rm_loaded: got v=%b want 1", out_valid); end
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++; if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin tests_failed++;
            $display("FAIL rm_async_clear: got v=%b rdy=%b want v=0 rdy=0000",
                     out_valid, in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 2, 4'b0000, 32'h00990000, 1'b1);
            tick();
            tests_run++; if (out_valid !== 1'b0) begin tests_failed++;
                $display("FAIL rm_no_redeliver[%0d]: got v=%b want 0", k, out_valid); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            apply(1'($urandom), int'($urandom_range(0, 3)), N_IN'($urandom),
                  (N_IN*WIDTH)'($urandom), ($urandom_range(0, 3) != 0));
            tests_run++; if (in_ready !== exp_ready) begin tests_failed++;
                $display("FAIL rand_in_ready[%0d]: got %b want %b", k, in_ready, exp_ready); end
            tick();
            tests_run++;
            if (out_valid !== m_valid || out_data !== m_data || int'(out_src) != m_src) begin
                tests_failed++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h src=%0d want v=%b d=%h src=%0d",
                         k, out_valid, out_data, out_src, m_valid, m_data, m_src);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; select = '0; in_data = '0; in_valid = '0; out_ready = 1'b1;
        model_reset();
        exp_g = -1; exp_ready = '0;
        @(posedge clk); #1;
        test_reset();
        test_sel_basic();
        test_rr_fairness();
        test_backpressure();
        test_mode_switch();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
